// File: rtl/phase_seq.sv
// phase_seq: multi-cycle instruction phase sequencer.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// stretching phases on memory wait states and mult/div busy, counting
// retired instructions, and parking in a halted state when asked to stop.
module phase_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  irfunc,
  input  logic [4:0]  regimm,
  input  logic        mem_ready,
  input  logic        md_busy,
  input  logic        halt_req,
  output logic [4:0]  p,
  output logic        md_start,
  output logic        illegal,
  output logic        halted,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_F = 3'd0,
    S_D = 3'd1,
    S_E = 3'd2,
    S_M = 3'd3,
    S_W = 3'd4,
    S_H = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BR,
    C_JMP,
    C_MD,
    C_ILL
  } cls_e;

  state_e      state_q, state_d;
  logic        e_held_q, e_held_d;  // execute has already lasted one cycle
  logic [31:0] instr_cnt_q;
  logic        retire;
  cls_e        cls;

  // Instruction class from the opcode, funct and rt fields.
  // NOTE: every signal written in a combinational block gets a default first;
  // a path that leaves one unassigned infers a latch.
  always_comb begin
    cls = C_ILL;
    case (op)
      6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101: cls = C_LOAD;
      6'b101011, 6'b101001, 6'b101000:                       cls = C_STORE;
      6'b000100, 6'b000101, 6'b000110, 6'b000111:            cls = C_BR;
      6'b000001: if (regimm == 5'b00000 || regimm == 5'b00001) cls = C_BR;
      6'b000010, 6'b000011:                                  cls = C_JMP;
      6'b001001, 6'b001100, 6'b001101, 6'b001110,
      6'b001010, 6'b001011, 6'b001111:                       cls = C_ALU;
      6'b000000: begin
        case (irfunc)
          6'b001000, 6'b001001:                         cls = C_JMP;
          6'b011000, 6'b011001, 6'b011010, 6'b011011:   cls = C_MD;
          6'b100000, 6'b100010, 6'b100011, 6'b100100,
          6'b100101, 6'b100110, 6'b100111, 6'b101010,
          6'b101011, 6'b000000, 6'b000010, 6'b000011,
          6'b000100, 6'b000110, 6'b000111, 6'b010000,
          6'b010001, 6'b010010, 6'b010011:              cls = C_ALU;
          default:                                      cls = C_ILL;
        endcase
      end
      default: cls = C_ILL;
    endcase
  end

  // Next-state logic, pulse outputs and the instruction-boundary decision.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    md_start = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_F: if (mem_ready) state_d = S_D;
      S_D: begin
        if (cls == C_ILL) begin
          illegal = 1'b1;
          retire  = 1'b1;
        end else begin
          state_d = S_E;
        end
      end
      S_E: begin
        md_start = (cls == C_MD) && !e_held_q;
        case (cls)
          C_LOAD, C_STORE: state_d = S_M;
          C_ALU, C_JMP:    state_d = S_W;
          C_MD:            if (e_held_q && !md_busy) state_d = S_W;
          default:         retire = 1'b1;  // branch (or an opcode that changed mid-flight)
        endcase
      end
      S_M: begin
        if (mem_ready) begin
          if (cls == C_STORE) retire  = 1'b1;
          else                state_d = S_W;
        end
      end
      S_W: retire  = 1'b1;
      S_H: state_d = S_H;
      default: state_d = S_F;  // unused encodings recover to fetch
    endcase
    if (retire) state_d = halt_req ? S_H : S_F;
  end

  assign e_held_d = (state_q == S_E) && (state_d == S_E);

  // State, execute-hold flag and retired-instruction counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_F;
      e_held_q    <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      e_held_q <= e_held_d;
      if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  // One-hot phase to the control unit; zero while halted.
  always_comb begin
    p = 5'b00000;
    case (state_q)
      S_F:     p = 5'b00001;
      S_D:     p = 5'b00010;
      S_E:     p = 5'b00100;
      S_M:     p = 5'b01000;
      S_W:     p = 5'b10000;
      default: p = 5'b00000;
    endcase
  end

  assign halted    = (state_q == S_H);
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_phase_seq.sv
// Testbench for phase_seq: decode table, directed multi-cycle corner
// sequences, and randomized instructions with random wait states checked
// against a phase-list model built from the class timing rules.
module tb_phase_seq;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3,
                 K_JMP = 4, K_MD = 5, K_ILL = 6;
  localparam int PH_F = 0, PH_D = 1, PH_E = 2, PH_M = 3, PH_W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = '0;
  logic [5:0]  irfunc = '0;
  logic [4:0]  regimm = '0;
  logic        mem_ready = 1'b0;
  logic        md_busy = 1'b0;
  logic        halt_req = 1'b0;
  logic [4:0]  p;
  logic        md_start;
  logic        illegal;
  logic        halted;
  logic [31:0] instr_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = '0;

  phase_seq dut (
    .clk(clk), .reset(reset), .op(op), .irfunc(irfunc), .regimm(regimm),
    .mem_ready(mem_ready), .md_busy(md_busy), .halt_req(halt_req),
    .p(p), .md_start(md_start), .illegal(illegal), .halted(halted),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference classification written straight from the opcode lists.
  function automatic int model_class(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    if (o inside {6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101}) return K_LOAD;
    if (o inside {6'b101011, 6'b101001, 6'b101000}) return K_STORE;
    if (o inside {6'b000100, 6'b000101, 6'b000110, 6'b000111}) return K_BR;
    if (o == 6'b000001 && r inside {5'b00000, 5'b00001}) return K_BR;
    if (o inside {6'b000010, 6'b000011}) return K_JMP;
    if (o == 6'b000000 && f inside {6'b001000, 6'b001001}) return K_JMP;
    if (o == 6'b000000 && f inside {6'b011000, 6'b011001, 6'b011010, 6'b011011}) return K_MD;
    if (o inside {6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011, 6'b001111})
      return K_ALU;
    if (o == 6'b000000 && f inside {6'b100000, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                                     6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000,
                                     6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                                     6'b010000, 6'b010001, 6'b010010, 6'b010011})
      return K_ALU;
    return K_ILL;
  endfunction

  // Apply reset for one edge and check the reset state.
  task automatic reset_dut();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'($urandom % 2);
    md_busy   = 1'($urandom % 2);
    halt_req  = 1'($urandom % 2);
    @(negedge clk);
    check("reset_p", 32'(p), 32'h01);
    check("reset_halted", 32'(halted), 32'h0);
    check("reset_md_start", 32'(md_start), 32'h0);
    check("reset_illegal", 32'(illegal), 32'h0);
    check("reset_cnt", instr_cnt, 32'h0);
    reset     = 1'b0;
    mem_ready = 1'b0;
    halt_req  = 1'b0;
    exp_cnt   = '0;
  endtask

  // Run one instruction from F. fw/mw are fetch/memory wait states, b is the
  // number of md_busy cycles counted from the md_start cycle. With halt set,
  // halt_req is held high from decode onward.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                           input int cls, input int fw, input int mw, input int b,
                           input bit halt);
    int ph[$];
    int ne, fi, mi, ei;
    ne = 1;
    if (cls == K_MD) ne = (b + 1 > 2) ? b + 1 : 2;
    repeat (fw + 1) ph.push_back(PH_F);
    ph.push_back(PH_D);
    if (cls != K_ILL) repeat (ne) ph.push_back(PH_E);
    if (cls == K_LOAD || cls == K_STORE) repeat (mw + 1) ph.push_back(PH_M);
    if (cls inside {K_ALU, K_JMP, K_MD, K_LOAD}) ph.push_back(PH_W);

    op = o; irfunc = f; regimm = r;
    fi = 0; mi = 0; ei = 0;
    for (int k = 0; k < ph.size(); k++) begin
      @(negedge clk);
      check($sformatf("p[op=%b fn=%b cyc=%0d]", o, f, k), 32'(p), 32'(1) << ph[k]);
      check("md_start", 32'(md_start), 32'(cls == K_MD && ph[k] == PH_E && ei == 0));
      check("illegal", 32'(illegal), 32'(cls == K_ILL && ph[k] == PH_D));
      check("halted_run", 32'(halted), 32'h0);
      mem_ready = 1'($urandom % 2);
      md_busy   = 1'($urandom % 2);
      halt_req  = halt && (ph[k] != PH_F);
      case (ph[k])
        PH_F: begin mem_ready = (fi == fw); fi++; end
        PH_M: begin mem_ready = (mi == mw); mi++; end
        PH_E: begin if (cls == K_MD) md_busy = (ei < b); ei++; end
        default: ;
      endcase
    end
    exp_cnt = exp_cnt + 32'd1;
    @(negedge clk);
    check("after_p", 32'(p), halt ? 32'h00 : 32'h01);
    check("after_halted", 32'(halted), 32'(halt));
    check("after_cnt", instr_cnt, exp_cnt);
    mem_ready = 1'b0;
    halt_req  = 1'b0;
    md_busy   = 1'($urandom % 2);
  endtask

  // Hold in H with busy inputs and confirm nothing moves.
  task automatic check_halted(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      mem_ready = 1'($urandom % 2);
      md_busy   = 1'($urandom % 2);
      halt_req  = 1'($urandom % 2);
      op        = 6'($urandom);
      @(negedge clk);
      check("h_p", 32'(p), 32'h0);
      check("h_halted", 32'(halted), 32'h1);
      check("h_md_start", 32'(md_start), 32'h0);
      check("h_illegal", 32'(illegal), 32'h0);
      check("h_cnt", instr_cnt, exp_cnt);
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    int         cls;
  } vec_t;

  vec_t vecs[$];
  logic [5:0] pool [0:21] = '{6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101,
                              6'b101011, 6'b101001, 6'b101000, 6'b000100, 6'b000101,
                              6'b000110, 6'b000111, 6'b000001, 6'b000010, 6'b000011,
                              6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010,
                              6'b001011, 6'b001111};

  initial begin
    vecs.push_back('{6'b000000, 6'b100000, 5'd0, K_ALU});    // add
    vecs.push_back('{6'b000000, 6'b010011, 5'd0, K_ALU});    // mtlo
    vecs.push_back('{6'b001111, 6'b000000, 5'd0, K_ALU});    // lui
    vecs.push_back('{6'b001000, 6'b000000, 5'd0, K_ILL});    // addi not supported
    vecs.push_back('{6'b100101, 6'b000000, 5'd0, K_LOAD});   // lhu
    vecs.push_back('{6'b101000, 6'b000000, 5'd0, K_STORE});  // sb
    vecs.push_back('{6'b000111, 6'b000000, 5'd0, K_BR});     // bgtz
    vecs.push_back('{6'b000001, 6'b000000, 5'd1, K_BR});     // bgez
    vecs.push_back('{6'b000001, 6'b000000, 5'd2, K_ILL});    // regimm rt out of set
    vecs.push_back('{6'b000011, 6'b000000, 5'd0, K_JMP});    // jal
    vecs.push_back('{6'b000000, 6'b001001, 5'd0, K_JMP});    // jalr
    vecs.push_back('{6'b000000, 6'b011011, 5'd0, K_MD});     // divu
    vecs.push_back('{6'b000000, 6'b000001, 5'd0, K_ILL});    // funct hole
    vecs.push_back('{6'b000000, 6'b001010, 5'd0, K_ILL});    // movz not supported
    vecs.push_back('{6'b111111, 6'b100000, 5'd0, K_ILL});

    reset_dut();

    // Decode table with zero wait states (cycle counts follow from the phase lists).
    foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].fn, vecs[i].rt, vecs[i].cls, 0, 0, 0, 1'b0);

    // add straight after reset.
    reset_dut();
    run_instr(6'b000000, 6'b100000, 5'd0, K_ALU, 0, 0, 0, 1'b0);
    // lw with three memory wait states.
    run_instr(6'b100011, 6'b000000, 5'd0, K_LOAD, 0, 3, 0, 1'b0);
    // mult with md_busy for 5 cycles from md_start: E held 6 cycles.
    run_instr(6'b000000, 6'b011000, 5'd0, K_MD, 0, 0, 5, 1'b0);
    // MD minimum execute of 2 cycles even with md_busy low throughout.
    run_instr(6'b000000, 6'b011010, 5'd0, K_MD, 2, 0, 0, 1'b0);
    // beq then an undecodable opcode.
    reset_dut();
    run_instr(6'b000100, 6'b000000, 5'd0, K_BR, 0, 0, 0, 1'b0);
    run_instr(6'b111111, 6'b000000, 5'd0, K_ILL, 0, 0, 0, 1'b0);
    check("beq_ill_cnt", instr_cnt, 32'd2);

    // sw with halt_req raised from decode on, including memory stalls.
    run_instr(6'b101011, 6'b000000, 5'd0, K_STORE, 1, 2, 0, 1'b1);
    check_halted(3);
    reset_dut();

    // Reset during a memory stall.
    op = 6'b100011; irfunc = '0; regimm = '0;
    mem_ready = 1'b1;
    @(negedge clk);  // F
    mem_ready = 1'b0;
    @(negedge clk);  // D
    @(negedge clk);  // E
    @(negedge clk);
    check("stall_p", 32'(p), 32'h08);
    @(negedge clk);
    check("stall_hold_p", 32'(p), 32'h08);
    reset_dut();

    // Counter wrap: preload all ones, retire one ALU instruction.
    @(negedge clk);
    dut.instr_cnt_q = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    run_instr(6'b001101, 6'b000000, 5'd0, K_ALU, 0, 0, 0, 1'b0);
    check("wrap_cnt", instr_cnt, 32'h0);

    // Randomized instructions and wait states against the model.
    reset_dut();
    for (int n = 0; n < 300; n++) begin
      logic [5:0] o, f;
      logic [4:0] r;
      bit h;
      case ($urandom % 4)
        0:       o = 6'b000000;
        1:       o = pool[$urandom % 22];
        default: o = 6'($urandom);
      endcase
      f = 6'($urandom);
      r = 5'($urandom_range(0, 3));
      h = ($urandom % 20) == 0;
      run_instr(o, f, r, model_class(o, f, r), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 6), h);
      if (h) begin
        check_halted(2);
        reset_dut();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_seq.md
PHASE_SEQ -- requirements
Module: phase_seq

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 op  in  6  opcode field from instruction register; valid from p1 onward.
REQ-004 irfunc  in  6  funct field from instruction register.
REQ-005 regimm  in  5  rt field, used only for op 000001.
REQ-006 mem_ready  in  1  memory handshake; 1 = current access completes this cycle.
REQ-007 md_busy  in  1  mult/div unit busy.
REQ-008 halt_req  in  1  request to stop at the next instruction boundary.
REQ-009 p  out  5  one-hot phase to the control unit: p[0] fetch, p[1] decode, p[2] execute, p[3] memory, p[4] writeback.
REQ-010 md_start  out  1  one-cycle pulse starting mult/div.
REQ-011 illegal  out  1  one-cycle pulse on an undecodable instruction.
REQ-012 halted  out  1  sequencer stopped.
REQ-013 instr_cnt  out  32  retired-instruction count.

Function
REQ-014 States SHALL be F, D, E, M, W, H; p is one-hot of F..W and 5'b00000 in H.
REQ-015 Classes SHALL decode from op/irfunc/regimm in D, E, M and W:
- LOAD: op 100011, 100000, 100100, 100001, 100101.
- STORE: op 101011, 101001, 101000.
- BR: op 000100, 000101, 000110, 000111; op 000001 with regimm 00000/00001.
- JMP: op 000010, 000011; op 000000 with funct 001000/001001.
- MD: op 000000 with funct 011000/011001/011010/011011.
- ALU: op 001001, 001100, 001101, 001110, 001010, 001011, 001111; op 000000 with funct 100000, 100010, 100011, 100100, 100101, 100110, 100111, 101010, 101011, 000000, 000010, 000011, 000100, 000110, 000111, 010000, 010001, 010010, 010011.
- Everything else is ILLEGAL.
REQ-016 F SHALL hold while mem_ready=0; on mem_ready=1, next state is D.
REQ-017 D SHALL go to E for any legal class; for ILLEGAL it SHALL pulse illegal for one cycle, retire the instruction, and take the boundary transition (REQ-022).
REQ-018 E transitions:
- BR retires (boundary).
- STORE and LOAD go to M.
- ALU and JMP go to W.
- MD goes to W only in a cycle where md_busy=0 and E has been held at least 2 cycles.
REQ-019 md_start SHALL be 1 exactly in the first cycle of E for MD instructions; md_busy sampled in that first cycle is ignored.
REQ-020 M SHALL hold while mem_ready=0; on mem_ready=1, STORE retires (boundary) and LOAD goes to W.
REQ-021 W SHALL last exactly one cycle and then retire (boundary).
REQ-022 Boundary transition:
- instr_cnt increments by 1 (32-bit, wraps FFFFFFFF -> 0).
- Next state is H if halt_req=1 in that cycle, else F.
REQ-023 In H: halted=1, p=0, no outputs pulse, instr_cnt frozen; exit only by reset. A halt_req asserted mid-instruction SHALL NOT shorten or abort that instruction.
REQ-024 Resulting cycle counts with zero wait states: ALU/JMP 4, LOAD 5, STORE 4, BR 3, ILLEGAL 2, MD 3 + E cycles.
REQ-025 p SHALL always be one-hot or zero; any unreachable state encoding recovers to F on the next clock.

Reset
REQ-026 reset=1 at a clock edge SHALL force state F (p=5'b00001), md_start=0, illegal=0, halted=0, instr_cnt=0, overriding all other inputs including mid-stall and H.
REQ-027 In the first cycle after reset deasserts, the block SHALL be in F and obey REQ-016.

Verification
REQ-028 Reset, mem_ready=1, then op=000000/funct 100000 (add) -> p sequence 00001, 00010, 00100, 10000, 00001; instr_cnt=1.
REQ-029 lw (op 100011) with mem_ready=0 for 3 cycles in M -> p=01000 for 4 cycles, then 10000, then 00001; total 8 cycles.
REQ-030 mult (funct 011000) with md_busy=1 for 5 cycles after md_start -> md_start high exactly 1 cycle; E held 6 cycles; then W, then F.
REQ-031 beq (op 000100), then op 111111 -> beq gives p 00001, 00010, 00100 then F; op 111111 gives illegal pulse in D, then F; instr_cnt=2.
REQ-032 halt_req=1 raised during E of sw -> sw completes M, enters H with p=0 and halted=1, instr_cnt +1; reset then returns p=00001, halted=0, instr_cnt=0.
REQ-033 Preload instr_cnt near wrap (force to FFFFFFFF), retire one ALU instruction -> instr_cnt=0.
